// File: rtl/rv_gpio_bridge_pkg.sv
// Shared constants for the GPIO bridge: register offsets within a port window
// and the port stride.
package rv_gpio_bridge_pkg;

  localparam int GPIO_DATA_WIDTH  = 32;
  localparam int GPIO_PORT_STRIDE = 32'h20;
  localparam int GPIO_OFS_BITS    = 5;

  typedef enum logic [GPIO_OFS_BITS-1:0] {
    GPIO_OFS_OUT   = 5'h00,
    GPIO_OFS_OE    = 5'h04,
    GPIO_OFS_IN    = 5'h08,
    GPIO_OFS_STAT  = 5'h0C,
    GPIO_OFS_IRQEN = 5'h10
  } gpio_ofs_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser for one GPIO port: SYNC_STAGES flop chain per bit, plus a
// one-cycle-delayed copy used to flag rising edges of the synchronised value.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0]                  prev_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_reg <= '0;
      prev_reg  <= '0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins};
      prev_reg  <= chain_reg[SYNC_STAGES-1];
    end
  end

  assign in_sync = chain_reg[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev_reg;

endmodule

// File: rtl/rv_gpio_bridge.sv
// Memory-mapped GPIO peripheral: per-port OUT/OE/IN/STAT/IRQ_EN registers behind
// a single-cycle request/ack bus, with a registered level interrupt.
module rv_gpio_bridge
  import rv_gpio_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = GPIO_DATA_WIDTH,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_PORTS   = 2,
  parameter int PORT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            req_i,
  input  logic                            we_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            ack_o,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in_i,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out_o,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe_o,
  output logic                            irq_o
);

  localparam int PIDX_W = ADDR_WIDTH - GPIO_OFS_BITS;

  logic [PIDX_W-1:0]        port_idx;
  logic [GPIO_OFS_BITS-1:0] ofs;
  logic                     wr_en;
  logic [PORT_WIDTH-1:0]    wdata_port;
  logic [DATA_WIDTH-1:0]    port_rdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]     port_irq;
  logic [DATA_WIDTH-1:0]    rdata_next;

  logic                  ack_reg;
  logic                  irq_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  assign port_idx   = addr_i[ADDR_WIDTH-1:GPIO_OFS_BITS];
  assign ofs        = addr_i[GPIO_OFS_BITS-1:0];
  assign wr_en      = req_i & we_i;
  assign wdata_port = wdata_i[PORT_WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic                  port_sel;
      logic [PORT_WIDTH-1:0] out_reg;
      logic [PORT_WIDTH-1:0] oe_reg;
      logic [PORT_WIDTH-1:0] stat_reg;
      logic [PORT_WIDTH-1:0] irq_en_reg;
      logic [PORT_WIDTH-1:0] stat_next;
      logic [PORT_WIDTH-1:0] in_sync;
      logic [PORT_WIDTH-1:0] rise;
      logic [DATA_WIDTH-1:0] rdata_port;

      assign port_sel = (port_idx == PIDX_W'(gi));

      gpio_sync_edge #(
        .WIDTH       (PORT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .pins    (gpio_in_i[gi*PORT_WIDTH +: PORT_WIDTH]),
        .in_sync (in_sync),
        .rise    (rise)
      );

      // A rise in the same cycle as a write-1-to-clear keeps the flag set.
      always_comb begin
        stat_next = stat_reg | rise;
        if (wr_en && port_sel && (ofs == GPIO_OFS_STAT)) begin
          stat_next = (stat_reg & ~wdata_port) | rise;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          out_reg    <= '0;
          oe_reg     <= '0;
          stat_reg   <= '0;
          irq_en_reg <= '0;
        end else begin
          if (wr_en && port_sel) begin
            case (ofs)
              GPIO_OFS_OUT:   out_reg    <= wdata_port;
              GPIO_OFS_OE:    oe_reg     <= wdata_port;
              GPIO_OFS_IRQEN: irq_en_reg <= wdata_port;
              default: ;
            endcase
          end
          stat_reg <= stat_next;
        end
      end

      always_comb begin
        rdata_port = '0;
        case (ofs)
          GPIO_OFS_OUT:   rdata_port[PORT_WIDTH-1:0] = out_reg;
          GPIO_OFS_OE:    rdata_port[PORT_WIDTH-1:0] = oe_reg;
          GPIO_OFS_IN:    rdata_port[PORT_WIDTH-1:0] = in_sync;
          GPIO_OFS_STAT:  rdata_port[PORT_WIDTH-1:0] = stat_reg;
          GPIO_OFS_IRQEN: rdata_port[PORT_WIDTH-1:0] = irq_en_reg;
          default: ;
        endcase
      end

      assign port_rdata[gi] = rdata_port;
      assign port_irq[gi]   = |(stat_reg & irq_en_reg);
      assign gpio_out_o[gi*PORT_WIDTH +: PORT_WIDTH] = out_reg;
      assign gpio_oe_o[gi*PORT_WIDTH +: PORT_WIDTH]  = oe_reg;
    end

    if (PORT_WIDTH < DATA_WIDTH) begin : g_wdata_upper
      logic unused_wdata;
      assign unused_wdata = ^wdata_i[DATA_WIDTH-1:PORT_WIDTH];
    end
  endgenerate

  // Port indices past NUM_PORTS match no entry and read as zero.
  always_comb begin
    rdata_next = '0;
    if (req_i && !we_i) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_idx == PIDX_W'(p)) begin
          rdata_next = port_rdata[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      ack_reg   <= req_i;
      rdata_reg <= rdata_next;
      irq_reg   <= |port_irq;
    end
  end

  assign ack_o   = ack_reg;
  assign rdata_o = rdata_reg;
  assign irq_o   = irq_reg;

endmodule
